// File: rtl/aspiradora_pkg.sv
// Shared types and helpers for the robot vacuum controller.
package aspiradora_pkg;

  typedef enum logic [2:0] {
    StOff   = 3'd0,
    StIdle  = 3'd1,
    StClean = 3'd2,
    StEvade = 3'd3,
    StDock  = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned timer_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/aspiradora_ctrl_param_if.sv
// Switch inputs and status outputs of the vacuum controller.
interface aspiradora_ctrl_param_if #(
  parameter int unsigned CNT_W = 8
);
  logic             power_off_i;
  logic             on_i;
  logic             clean_i;
  logic             obstacle_i;
  logic [2:0]       state_o;
  logic             motor_o;
  logic             brush_o;
  logic             reverse_o;
  logic [CNT_W-1:0] evade_cnt_o;

  modport master (
    output power_off_i, on_i, clean_i, obstacle_i,
    input  state_o, motor_o, brush_o, reverse_o, evade_cnt_o
  );

  modport slave (
    input  power_off_i, on_i, clean_i, obstacle_i,
    output state_o, motor_o, brush_o, reverse_o, evade_cnt_o
  );
endinterface

// File: rtl/aspiradora_debounce.sv
// Two-flop synchroniser followed by a consecutive-mismatch debounce counter.
module aspiradora_debounce
  import aspiradora_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CntW = timer_w(DEB_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [CntW-1:0] r_cnt;
  logic            w_mismatch;

  assign w_mismatch = (r_sync2 != r_level);
  assign o_level    = r_level;

  // Synchronise, then flip the level after DEB_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CntOne;
      end
    end
  end

endmodule

// File: rtl/aspiradora_ctrl_param.sv
// Robot vacuum Moore controller: conditioned switches drive a five-state FSM.
module aspiradora_ctrl_param
  import aspiradora_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned EVADE_CYCLES = 200,
  parameter int unsigned CLEAN_CYCLES = 5000,
  parameter int unsigned DOCK_CYCLES  = 100,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  aspiradora_ctrl_param_if.slave  bus
);

  localparam int unsigned EvW = timer_w(EVADE_CYCLES);
  localparam int unsigned ClW = timer_w(CLEAN_CYCLES);
  localparam int unsigned DkW = timer_w(DOCK_CYCLES);

  localparam logic [EvW-1:0]   EvLast = EvW'(EVADE_CYCLES - 1);
  localparam logic [ClW-1:0]   ClLast = ClW'(CLEAN_CYCLES - 1);
  localparam logic [DkW-1:0]   DkLast = DkW'(DOCK_CYCLES - 1);
  localparam logic [EvW-1:0]   EvOne  = EvW'(1);
  localparam logic [ClW-1:0]   ClOne  = ClW'(1);
  localparam logic [DkW-1:0]   DkOne  = DkW'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic w_power_off, w_on, w_clean, w_obstacle;

  state_t           r_state, w_state_d;
  logic [EvW-1:0]   r_evade_t, w_evade_t_d;
  logic [ClW-1:0]   r_clean_t, w_clean_t_d;
  logic [DkW-1:0]   r_dock_t, w_dock_t_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] w_cnt_inc;

  aspiradora_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_power_off (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (bus.power_off_i),
    .o_level (w_power_off)
  );

  aspiradora_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_on (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (bus.on_i),
    .o_level (w_on)
  );

  aspiradora_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clean (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (bus.clean_i),
    .o_level (w_clean)
  );

  aspiradora_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_obstacle (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (bus.obstacle_i),
    .o_level (w_obstacle)
  );

  // Evade counter sticks at all-ones.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CntOne;

  // State, timer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StOff;
      r_evade_t <= '0;
      r_clean_t <= '0;
      r_dock_t  <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_evade_t <= w_evade_t_d;
      r_clean_t <= w_clean_t_d;
      r_dock_t  <= w_dock_t_d;
      r_cnt     <= w_cnt_d;
    end
  end

  // Next state: power_off, then obstacle, then timer expiry, then clean.
  always_comb begin
    w_state_d   = r_state;
    w_evade_t_d = r_evade_t;
    w_clean_t_d = r_clean_t;
    w_dock_t_d  = r_dock_t;
    w_cnt_d     = r_cnt;
    if (ena) begin
      if (w_power_off) begin
        w_state_d   = StOff;
        w_evade_t_d = '0;
        w_clean_t_d = '0;
        w_dock_t_d  = '0;
        w_cnt_d     = '0;
      end else begin
        case (r_state)
          StOff: begin
            if (w_on) w_state_d = StIdle;
          end
          StIdle: begin
            if (w_clean) w_state_d = StClean;
          end
          StClean: begin
            if (w_obstacle) begin
              w_state_d   = StEvade;
              w_evade_t_d = '0;
              w_cnt_d     = w_cnt_inc;
            end else if (r_clean_t == ClLast) begin
              w_state_d  = StDock;
              w_dock_t_d = '0;
            end else if (!w_clean) begin
              w_state_d = StIdle;
            end else begin
              w_clean_t_d = r_clean_t + ClOne;
            end
          end
          StEvade: begin
            if (r_evade_t == EvLast) begin
              if (w_obstacle) begin
                w_evade_t_d = '0;
                w_cnt_d     = w_cnt_inc;
              end else begin
                w_state_d = w_clean ? StClean : StIdle;
              end
            end else begin
              w_evade_t_d = r_evade_t + EvOne;
            end
          end
          StDock: begin
            if (r_dock_t == DkLast) begin
              w_state_d   = StIdle;
              w_clean_t_d = '0;
            end else begin
              w_dock_t_d = r_dock_t + DkOne;
            end
          end
          default: begin
            // Unused codes fall back to a clean OFF.
            w_state_d   = StOff;
            w_evade_t_d = '0;
            w_clean_t_d = '0;
            w_dock_t_d  = '0;
            w_cnt_d     = '0;
          end
        endcase
      end
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    bus.state_o     = r_state;
    bus.evade_cnt_o = r_cnt;
    bus.motor_o     = 1'b0;
    bus.brush_o     = 1'b0;
    bus.reverse_o   = 1'b0;
    case (r_state)
      StClean: begin
        bus.motor_o = 1'b1;
        bus.brush_o = 1'b1;
      end
      StEvade: begin
        bus.motor_o   = 1'b1;
        bus.reverse_o = 1'b1;
      end
      StDock: begin
        bus.motor_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/aspiradora_ctrl_param.md
Name: aspiradora_ctrl_param

Overview:
Parametrised next-generation Moore controller for the robot vacuum. It conditions raw switch inputs with a synchroniser and debouncer and drives a five-state FSM: OFF, IDLE, CLEAN, EVADE, DOCK. Evade, clean-session and dock durations are timed internally. Outputs are the state code, the motor, brush and reverse enables, and a saturating evade-event counter. It sits behind the TinyTapeout top wrapper, which maps ui_in[3:0] onto the four switch inputs and the outputs onto uo_out.

Parameters:
DEB_CYCLES, 16, consecutive stable cycles required before a debounced input changes (at least 1).
EVADE_CYCLES, 200, cycles spent in EVADE per entry (at least 1).
CLEAN_CYCLES, 5000, cumulative CLEAN cycles before automatic DOCK (at least 1).
DOCK_CYCLES, 100, cycles spent in DOCK (at least 1).
CNT_W, 8, width of the evade event counter.

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  reset, asynchronous assert, active-low.
ena  in  1  FSM/timer enable; when 0, the FSM, timers and counter hold.
power_off_i  in  1  raw switch SW0, asynchronous.
on_i  in  1  raw switch SW1.
clean_i  in  1  raw switch SW2, cleaning request (level).
obstacle_i  in  1  raw switch SW3, obstacle sensor (level).
state_o  out  3  state code: OFF=0, IDLE=1, CLEAN=2, EVADE=3, DOCK=4.
motor_o  out  1  high in CLEAN, EVADE or DOCK.
brush_o  out  1  high in CLEAN only.
reverse_o  out  1  high in EVADE only.
evade_cnt_o  out  CNT_W  number of EVADE entries since the last OFF; saturates.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - state=OFF, all enables 0, evade_cnt_o=0;
  - all timers 0;
  - synchroniser flops and debounced levels 0.
- Input conditioning, per input:
  - 2-flop synchroniser, then a debounce counter.
  - The debounced level takes the synchronised value once it has differed from the current debounced level for DEB_CYCLES consecutive cycles.
  - Any mismatch gap clears the counter.
  - Raw-to-debounced latency is exactly 2+DEB_CYCLES cycles.
  - Conditioning runs regardless of ena.
- FSM (Moore):
  - Next state is evaluated on debounced levels only when ena=1; outputs depend on the registered state only.
  - An input change reaches state_o one cycle after its debounced level changes.
  - Priority order: power_off, then obstacle, then timer expiry, then clean.
- Transitions:
  - Any state: power_off=1 -> OFF. Entry to OFF clears evade_cnt_o and all timers.
  - OFF: on=1 and power_off=0 -> IDLE; otherwise stay.
  - IDLE: clean=1 -> CLEAN. obstacle is ignored in IDLE.
  - CLEAN, checked in this order:
    - obstacle=1 -> EVADE; evade timer loads 0; evade_cnt_o increments unless already all-ones.
    - clean timer == CLEAN_CYCLES-1 -> DOCK.
    - clean=0 -> IDLE; the clean timer is kept, not cleared.
    - Otherwise the clean timer increments.
  - EVADE:
    - Evade timer increments each enabled cycle.
    - At EVADE_CYCLES-1 with obstacle=1: restart EVADE (timer to 0, counter increments, saturating).
    - At EVADE_CYCLES-1 with obstacle=0: go to CLEAN if clean=1, else IDLE.
    - The clean timer is frozen while in EVADE.
  - DOCK:
    - Dock timer increments.
    - At DOCK_CYCLES-1 -> IDLE, and the clean timer clears.
    - clean and obstacle are ignored in DOCK.
- Timer widths: $clog2 of each maximum count, minimum 1 bit. Timers never wrap; they are compared for equality with the terminal value.
- ena=0 mid-operation: state, timers and counter hold; outputs stay at the held-state values.
- Unused state codes 5..7 recover to OFF on the next enabled cycle.

Decomposition:
- Shared package aspiradora_pkg holds:
  - state_t enum, 3 bits, with the codes above;
  - the function for timer width, max($clog2(N),1).
- One sub-module, aspiradora_debounce: synchroniser plus counter, parameter DEB_CYCLES, instantiated 4 times.
- The FSM, timers and counter live in the top of this block.

Test Plan:
All scenarios use DEB_CYCLES=4, EVADE_CYCLES=8, CLEAN_CYCLES=32, DOCK_CYCLES=6, CNT_W=4.
1. Reset, then on_i=1 for 10 cycles -> state_o=1 exactly 7 cycles after the on_i rise; all enables 0.
2. on_i pulses for 3 cycles, or toggles every 2 cycles -> state_o stays 0 (debounce rejects the glitches).
3. In IDLE, clean_i=1 -> state_o=2, motor_o=1, brush_o=1. After 32 cumulative CLEAN cycles -> state_o=4 for 6 cycles, then state_o=1.
4. In CLEAN, pulse obstacle_i long enough to debounce -> state_o=3, reverse_o=1, brush_o=0 for exactly 8 cycles, then back to 2; evade_cnt_o=1. Holding obstacle_i high -> EVADE restarts and the counter increments every 8 cycles.
5. Cause 17 evades -> evade_cnt_o saturates at 15. Then power_off_i=1 -> state_o=0 and evade_cnt_o=0.
6. ena=0 during EVADE for 20 cycles -> state and timer hold. After ena=1, the remaining evade cycles complete. Assert rst_n=0 mid-DOCK -> outputs go to their reset values immediately, without waiting for a clock edge.
